// File: rtl/dir_pkg.sv
// Shared types for the direction input stage: direction codes as consumed by top1
// and the move-pacing FSM state encoding.
package dir_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    REPEAT = 2'd2
  } mv_state_e;

  // lvl bit order: [0]=up [1]=down [2]=left [3]=right; caller qualifies with |lvl
  function automatic dir_e dir_select(input logic [3:0] lvl);
    if (lvl[0]) return UP;
    if (lvl[1]) return DOWN;
    if (lvl[2]) return LEFT;
    return RIGHT;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button lane: 2-flop synchroniser followed by a counter debounce that
// only accepts a level held for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level
);

  logic                 s1, s2;
  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/dir_input_ctrl.sv
// Button front end for top1: debounce, direction priority, move strobe pacing and fire edge.
// Build option AUTO_REPEAT_EN: a held direction re-strobes sample every TICK_CYCLES.
module dir_input_ctrl
  import dir_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_CYCLES     = 20,
  parameter int CNT_WIDTH       = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fire,
  input  logic       enable,
  output logic [1:0] keyboard,
  output logic       sample,
  output logic       fire,
  output logic       held
);

  localparam int NUM_BTN = 5;
  // An out-of-range configuration keeps the strobes quiet so it shows up at bring-up.
  localparam bit PARAMS_OK = (DEBOUNCE_CYCLES >= 2) && (TICK_CYCLES >= 2);

  logic [NUM_BTN-1:0] raw, lvl;
  assign raw = {btn_fire, btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .btn  (raw[i]),
      .level(lvl[i])
    );
  end

  mv_state_e state, state_nxt;
  dir_e      kb_q, kb_nxt, sel;
  logic      sample_nxt, fire_q, any_dir, strobe_en;
`ifdef AUTO_REPEAT_EN
  logic [CNT_WIDTH-1:0] tick, tick_nxt;
`endif

  assign any_dir   = |lvl[3:0];
  assign sel       = dir_select(lvl[3:0]);
  assign strobe_en = enable & PARAMS_OK;
  assign keyboard  = kb_q;

  always_comb begin
    state_nxt  = state;
    kb_nxt     = kb_q;
    sample_nxt = 1'b0;
`ifdef AUTO_REPEAT_EN
    tick_nxt   = tick;
`endif
    case (state)
      IDLE: begin
        if (any_dir) begin
          kb_nxt    = sel;
          state_nxt = FIRST;
        end
      end
      FIRST: begin
        sample_nxt = strobe_en;
`ifdef AUTO_REPEAT_EN
        tick_nxt   = '0;
`endif
        state_nxt  = REPEAT;
      end
      REPEAT: begin
        // Release and re-selection win over a due repeat so keyboard never moves under a strobe.
        if (!any_dir) begin
          state_nxt = IDLE;
        end else if (sel != kb_q) begin
          kb_nxt    = sel;
          state_nxt = FIRST;
        end
`ifdef AUTO_REPEAT_EN
        else if (tick == CNT_WIDTH'(TICK_CYCLES - 1)) begin
          sample_nxt = strobe_en;
          tick_nxt   = '0;
        end else begin
          tick_nxt = tick + CNT_WIDTH'(1);
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      kb_q   <= UP;
      sample <= 1'b0;
      fire   <= 1'b0;
      fire_q <= 1'b0;
      held   <= 1'b0;
`ifdef AUTO_REPEAT_EN
      tick   <= '0;
`endif
    end else begin
      state  <= state_nxt;
      kb_q   <= kb_nxt;
      sample <= sample_nxt;
      held   <= any_dir;
      fire_q <= lvl[4];
      fire   <= strobe_en & lvl[4] & ~fire_q;
`ifdef AUTO_REPEAT_EN
      tick   <= tick_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_dir_input_ctrl.sv
// Bench for dir_input_ctrl: directed scenarios plus randomized button traffic
// against a timestamp-based behavioural model.
module tb_dir_input_ctrl;

  localparam int D  = 4;
  localparam int TK = 20;
`ifdef AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b1;
  logic [4:0] bvec = '0;   // [0]=up [1]=down [2]=left [3]=right [4]=fire
  logic       btn_up, btn_down, btn_left, btn_right, btn_fire;
  logic [1:0] keyboard;
  logic       sample, fire, held;

  assign {btn_fire, btn_right, btn_left, btn_down, btn_up} = bvec;

  dir_input_ctrl #(.DEBOUNCE_CYCLES(D), .TICK_CYCLES(TK), .CNT_WIDTH(20)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_fire(btn_fire),
    .enable(enable),
    .keyboard(keyboard), .sample(sample), .fire(fire), .held(held)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: explicit two-stage delay, then "last D synced samples all differ" acceptance,
  // then move pacing expressed as the edge index of the most recent first strobe.
  bit [4:0]   m_s1, m_s2, m_db;
  bit [4:0]   s2hist[$];
  bit         m_fq, m_active;
  bit [1:0]   m_kb;
  bit         m_sample, m_fire, m_held;
  int         e = 0, first_t = 0;

  function automatic bit [1:0] m_pick(input bit [3:0] d);
    if (d[0]) return 2'd0;
    else if (d[1]) return 2'd1;
    else if (d[2]) return 2'd2;
    else return 2'd3;
  endfunction

  task model_edge;
    bit [4:0] db_old;
    bit       any, alldiff;
    bit [1:0] s;
    e++;
    if (!rst) begin
      s2hist.delete();
      m_s1 = '0; m_s2 = '0; m_db = '0; m_fq = 0; m_active = 0;
      m_kb = 2'd0; m_sample = 0; m_fire = 0; m_held = 0;
    end else begin
      db_old = m_db;
      s2hist.push_back(m_s2);
      if (s2hist.size() > D) void'(s2hist.pop_front());
      for (int b = 0; b < 5; b++) begin
        alldiff = (s2hist.size() == D);
        for (int k = 0; k < s2hist.size(); k++)
          if (s2hist[k][b] == db_old[b]) alldiff = 0;
        if (alldiff) m_db[b] = ~db_old[b];
      end
      m_s2 = m_s1;
      m_s1 = bvec;
      any = |db_old[3:0];
      s = m_pick(db_old[3:0]);
      m_sample = 0;
      if (!m_active) begin
        if (any) begin m_kb = s; m_active = 1; first_t = e + 1; end
      end else if (e == first_t) begin
        m_sample = enable;
      end else if (!any) begin
        m_active = 0;
      end else if (s != m_kb) begin
        m_kb = s; first_t = e + 1;
      end else if (AUTO && ((e - first_t) % TK == 0)) begin
        m_sample = enable;
      end
      m_held = any;
      m_fire = enable & db_old[4] & ~m_fq;
      m_fq   = db_old[4];
    end
  endtask

  task step;
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task test_reset;
    rst = 0; bvec = '1; enable = 1;
    for (int c = 1; c <= 10; c++) begin
      step();
      n_chk++;
      if ({keyboard, sample, fire, held} !== 5'b0) begin
        n_err++;
        $display("FAIL reset c=%0d got kb/s/f/h=%b required 00000", c, {keyboard, sample, fire, held});
      end
    end
    bvec = '0;
    step();
    rst = 1;
    for (int c = 1; c <= 10; c++) begin
      step();
      n_chk++;
      if ({keyboard, sample, fire, held} !== {m_kb, m_sample, m_fire, m_held}) begin
        n_err++;
        $display("FAIL reset_release c=%0d got %b required %b", c, {keyboard, sample, fire, held}, {m_kb, m_sample, m_fire, m_held});
      end
    end
  endtask

  task test_clean_press;
    int np;
    np = 0;
    bvec[3] = 1;
    for (int c = 1; c <= 70; c++) begin
      step();
      n_chk++;
      if ({keyboard, sample, fire, held} !== {m_kb, m_sample, m_fire, m_held}) begin
        n_err++;
        $display("FAIL clean_model c=%0d got %b required %b", c, {keyboard, sample, fire, held}, {m_kb, m_sample, m_fire, m_held});
      end
      if (sample) np++;
      if (c == 6) begin
        n_chk++;
        if (held !== 1'b0) begin n_err++; $display("FAIL clean_held_early got %b required 0", held); end
      end
      if (c == 7) begin
        n_chk++;
        if ({keyboard, held} !== 3'b111) begin n_err++; $display("FAIL clean_kb7 got %b required 111", {keyboard, held}); end
      end
      if (c == 8) begin
        n_chk++;
        if (sample !== 1'b1) begin n_err++; $display("FAIL clean_first_sample got %b required 1", sample); end
      end
    end
    n_chk++;
    if (np != (AUTO ? 4 : 1)) begin
      n_err++;
      $display("FAIL clean_pulse_count got %0d required %0d", np, AUTO ? 4 : 1);
    end
    bvec[3] = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      n_chk++;
      if ({keyboard, sample, fire, held} !== {m_kb, m_sample, m_fire, m_held}) begin
        n_err++;
        $display("FAIL clean_release c=%0d got %b required %b", c, {keyboard, sample, fire, held}, {m_kb, m_sample, m_fire, m_held});
      end
    end
  endtask

  task test_bounce;
    logic [1:0] kb0;
    int         ns;
    kb0 = keyboard; ns = 0;
    for (int c = 0; c < 40; c++) begin
      bvec[2] = (c < 20) && ((c % 4) < 2);
      step();
      if (sample) ns++;
      n_chk++;
      if ({keyboard, sample, fire, held} !== {m_kb, m_sample, m_fire, m_held}) begin
        n_err++;
        $display("FAIL bounce_model c=%0d got %b required %b", c, {keyboard, sample, fire, held}, {m_kb, m_sample, m_fire, m_held});
      end
    end
    n_chk++;
    if (ns != 0 || keyboard !== kb0) begin
      n_err++;
      $display("FAIL bounce got samples=%0d kb=%0d required samples=0 kb=%0d", ns, keyboard, kb0);
    end
  endtask

  task test_priority;
    bvec[3] = 1;
    for (int c = 1; c <= 40; c++) begin
      step();
      n_chk++;
      if ({keyboard, sample, fire, held} !== {m_kb, m_sample, m_fire, m_held}) begin
        n_err++;
        $display("FAIL prio_right c=%0d got %b required %b", c, {keyboard, sample, fire, held}, {m_kb, m_sample, m_fire, m_held});
      end
    end
    n_chk++;
    if (keyboard !== 2'b11) begin n_err++; $display("FAIL prio_before got %b required 11", keyboard); end
    bvec[0] = 1;
    for (int c = 1; c <= 40; c++) begin
      step();
      n_chk++;
      if ({keyboard, sample, fire, held} !== {m_kb, m_sample, m_fire, m_held}) begin
        n_err++;
        $display("FAIL prio_up c=%0d got %b required %b", c, {keyboard, sample, fire, held}, {m_kb, m_sample, m_fire, m_held});
      end
      if (c == 7) begin
        n_chk++;
        if ({keyboard, sample} !== 3'b000) begin n_err++; $display("FAIL prio_switch got kb/s=%b required 000", {keyboard, sample}); end
      end
      if (c == 8) begin
        n_chk++;
        if (sample !== 1'b1) begin n_err++; $display("FAIL prio_first got %b required 1", sample); end
      end
      if (c == 28) begin
        n_chk++;
        if (sample !== AUTO) begin n_err++; $display("FAIL prio_repeat got %b required %b", sample, AUTO); end
      end
    end
    bvec = '0;
    for (int c = 1; c <= 20; c++) begin
      step();
      n_chk++;
      if ({keyboard, sample, fire, held} !== {m_kb, m_sample, m_fire, m_held}) begin
        n_err++;
        $display("FAIL prio_release c=%0d got %b required %b", c, {keyboard, sample, fire, held}, {m_kb, m_sample, m_fire, m_held});
      end
    end
  endtask

  task test_fire;
    int nf;
    for (int phase = 0; phase < 2; phase++) begin
      nf = 0;
      enable = (phase == 0);
      bvec[4] = 1;
      for (int c = 1; c <= 120; c++) begin
        if (phase == 1 && c == 31) enable = 1;
        if (c == 101) bvec[4] = 0;
        step();
        if (fire) nf++;
        n_chk++;
        if ({keyboard, sample, fire, held} !== {m_kb, m_sample, m_fire, m_held}) begin
          n_err++;
          $display("FAIL fire_model p=%0d c=%0d got %b required %b", phase, c, {keyboard, sample, fire, held}, {m_kb, m_sample, m_fire, m_held});
        end
      end
      n_chk++;
      if (nf != (phase == 0 ? 1 : 0)) begin
        n_err++;
        $display("FAIL fire_count p=%0d got %0d required %0d", phase, nf, phase == 0 ? 1 : 0);
      end
    end
    enable = 1;
  endtask

  task test_random;
    int r, b, len, g;
    for (int seg = 0; seg < 150; seg++) begin
      r = $urandom_range(0, 19);
      if (r < 10) begin
        b = $urandom_range(0, 4);
        bvec[b] = ~bvec[b];
        g = 0;
      end else if (r < 14) begin
        b = $urandom_range(0, 4);
        g = $urandom_range(1, D - 1);
        bvec[b] = ~bvec[b];
      end else if (r < 18) begin
        enable = ~enable;
        g = 0;
      end else begin
        rst = 0;
        g = $urandom_range(1, 2);
      end
      len = $urandom_range(8, 40);
      for (int c = 0; c < g + len; c++) begin
        step();
        n_chk++;
        if ({keyboard, sample, fire, held} !== {m_kb, m_sample, m_fire, m_held}) begin
          n_err++;
          $display("FAIL random seg=%0d c=%0d got %b required %b", seg, c, {keyboard, sample, fire, held}, {m_kb, m_sample, m_fire, m_held});
        end
        if (c == g - 1) begin
          if (r >= 10 && r < 14) bvec[b] = ~bvec[b];
          rst = 1;
        end
      end
    end
    bvec = '0; enable = 1; rst = 1;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_priority();
    test_fire();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
